// File: rtl/conbox_cfg.sv
// conbox_cfg: connection box joining NUM_LE logic elements to one interleaved
// switchbox track bus. Track t of lane k is bus bit t*NUM_LE+k.
//
// Configuration is loaded serially into a shadow register. A commit copies it
// atomically into the active register, but only if exactly CFG_BITS bits were
// shifted since the last commit or reset.
//
// Ports:
//   clk, nrst              clock, asynchronous active-low reset
//   cfg_en, cfg_in         scan shift enable and scan data in
//   cfg_out                scan data out (shadow MSB), for daisy-chaining
//   cfg_commit             copy shadow to active when the bit count is right
//   cfg_valid              an active configuration is loaded
//   cfg_err                sticky: last commit had the wrong bit count
//   sb_in                  track values from the switchboxes
//   sb_out, sb_oe          track drive values and per-track drive enables
//   le_out                 LE outputs, LE k output o at bit k*LE_OUTPUTS+o
//   le_in                  LE inputs, LE k input i at bit k*LE_INPUTS+i
module conbox_cfg #(
    parameter int WIDTH      = 8,
    parameter int NUM_LE     = 2,
    parameter int LE_INPUTS  = 4,
    parameter int LE_OUTPUTS = 1
) (
    input  logic                         clk,
    input  logic                         nrst,
    input  logic                         cfg_en,
    input  logic                         cfg_in,
    output logic                         cfg_out,
    input  logic                         cfg_commit,
    output logic                         cfg_valid,
    output logic                         cfg_err,
    input  logic [WIDTH*NUM_LE-1:0]      sb_in,
    output logic [WIDTH*NUM_LE-1:0]      sb_out,
    output logic [WIDTH*NUM_LE-1:0]      sb_oe,
    input  logic [NUM_LE*LE_OUTPUTS-1:0] le_out,
    output logic [NUM_LE*LE_INPUTS-1:0]  le_in
);

    localparam int SEL_BITS  = $clog2(WIDTH + 2);
    localparam int TOTAL_MUX = LE_INPUTS + LE_OUTPUTS;
    localparam int REG_BASE  = NUM_LE * TOTAL_MUX * SEL_BITS;
    localparam int CFG_BITS  = REG_BASE + NUM_LE * LE_INPUTS;
    localparam int CNT_W     = $clog2(CFG_BITS + 2);
    localparam int NUM_IN    = NUM_LE * LE_INPUTS;
    localparam int EXT       = 2 ** SEL_BITS;

    logic [CFG_BITS-1:0] shadow_q, shadow_d;
    logic [CFG_BITS-1:0] active_q, active_d;
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic                valid_q, valid_d;
    logic                err_q, err_d;
    logic [NUM_IN-1:0]   in_reg_q, in_reg_d;
    logic [NUM_IN-1:0]   mux_v;

    // Shift takes priority over commit when both are requested.
    always_comb begin
        shadow_d  = shadow_q;
        active_d  = active_q;
        bit_cnt_d = bit_cnt_q;
        valid_d   = valid_q;
        err_d     = err_q;
        if (cfg_en) begin
            shadow_d = {shadow_q[CFG_BITS-2:0], cfg_in};
            // Saturate one past CFG_BITS so an over-long load still fails.
            if (bit_cnt_q != CNT_W'(CFG_BITS + 1)) begin
                bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
        end else if (cfg_commit) begin
            if (bit_cnt_q == CNT_W'(CFG_BITS)) begin
                active_d = shadow_q;
                valid_d  = 1'b1;
                err_d    = 1'b0;
            end else begin
                err_d = 1'b1;
            end
            bit_cnt_d = '0;
        end
    end

    // Input flops are held at zero while no configuration is active.
    assign in_reg_d = valid_q ? mux_v : '0;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            shadow_q  <= '0;
            active_q  <= '0;
            bit_cnt_q <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            in_reg_q  <= '0;
        end else begin
            shadow_q  <= shadow_d;
            active_q  <= active_d;
            bit_cnt_q <= bit_cnt_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            in_reg_q  <= in_reg_d;
        end
    end

    assign cfg_out   = shadow_q[CFG_BITS-1];
    assign cfg_valid = valid_q;
    assign cfg_err   = err_q;

    for (genvar k = 0; k < NUM_LE; k++) begin : g_le
        // Lane k extended to every select code: tracks, then constant 0, 1
        // and zero for the unused codes, so the select indexes it directly.
        logic [EXT-1:0] ext;
        for (genvar t = 0; t < EXT; t++) begin : g_ext
            if (t < WIDTH) begin : g_trk
                assign ext[t] = sb_in[t*NUM_LE+k];
            end else if (t == WIDTH + 1) begin : g_one
                assign ext[t] = 1'b1;
            end else begin : g_zero
                assign ext[t] = 1'b0;
            end
        end

        for (genvar i = 0; i < LE_INPUTS; i++) begin : g_in
            localparam int IDX = k * LE_INPUTS + i;
            logic [SEL_BITS-1:0] sel;
            assign sel        = active_q[((k*TOTAL_MUX)+i)*SEL_BITS +: SEL_BITS];
            assign mux_v[IDX] = ext[sel];
            assign le_in[IDX] = valid_q &
                                (active_q[REG_BASE+IDX] ? in_reg_q[IDX] : mux_v[IDX]);
        end

        logic [SEL_BITS-1:0] osel [LE_OUTPUTS];
        for (genvar o = 0; o < LE_OUTPUTS; o++) begin : g_osel
            assign osel[o] = active_q[((k*TOTAL_MUX)+LE_INPUTS+o)*SEL_BITS +: SEL_BITS];
        end

        for (genvar t = 0; t < WIDTH; t++) begin : g_drv
            logic [LE_OUTPUTS-1:0] hit;
            logic [LE_OUTPUTS-1:0] first;
            for (genvar o = 0; o < LE_OUTPUTS; o++) begin : g_hit
                assign hit[o] = (osel[o] == SEL_BITS'(t));
            end
            // Lowest-numbered output claiming this track is the only driver.
            assign first = hit & (~hit + LE_OUTPUTS'(1));
            assign sb_oe[t*NUM_LE+k]  = valid_q & (|hit);
            assign sb_out[t*NUM_LE+k] = valid_q &
                                        (|(first & le_out[k*LE_OUTPUTS +: LE_OUTPUTS]));
        end
    end

endmodule

// File: tb/tb_conbox_cfg.sv
// Self-checking bench for conbox_cfg: randomized track/LE traffic with
// directed and random configuration loads, checked by a scoreboard against
// a behavioural model of the scan chain and routing rules.
module tb_conbox_cfg;

    localparam int WIDTH      = 8;
    localparam int NUM_LE     = 2;
    localparam int LE_INPUTS  = 4;
    localparam int LE_OUTPUTS = 1;
    localparam int SEL_BITS   = $clog2(WIDTH + 2);
    localparam int TOTAL_MUX  = LE_INPUTS + LE_OUTPUTS;
    localparam int REG_BASE   = NUM_LE * TOTAL_MUX * SEL_BITS;
    localparam int CFG_BITS   = REG_BASE + NUM_LE * LE_INPUTS;
    localparam int NT         = WIDTH * NUM_LE;
    localparam int NI         = NUM_LE * LE_INPUTS;
    localparam int NO         = NUM_LE * LE_OUTPUTS;

    logic          clk = 1'b0;
    logic          nrst;
    logic          cfg_en, cfg_in, cfg_commit;
    logic          cfg_out, cfg_valid, cfg_err;
    logic [NT-1:0] sb_in, sb_out, sb_oe;
    logic [NO-1:0] le_out;
    logic [NI-1:0] le_in;

    conbox_cfg #(
        .WIDTH     (WIDTH),
        .NUM_LE    (NUM_LE),
        .LE_INPUTS (LE_INPUTS),
        .LE_OUTPUTS(LE_OUTPUTS)
    ) dut (
        .clk       (clk),
        .nrst      (nrst),
        .cfg_en    (cfg_en),
        .cfg_in    (cfg_in),
        .cfg_out   (cfg_out),
        .cfg_commit(cfg_commit),
        .cfg_valid (cfg_valid),
        .cfg_err   (cfg_err),
        .sb_in     (sb_in),
        .sb_out    (sb_out),
        .sb_oe     (sb_oe),
        .le_out    (le_out),
        .le_in     (le_in)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NI-1:0] le_in;
        logic [NT-1:0] oe;
        logic [NT-1:0] out;
        logic          valid;
        logic          err;
        logic          cout;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state.
    logic [CFG_BITS-1:0] m_shadow;
    logic [CFG_BITS-1:0] m_active;
    int                  m_cnt;
    logic                m_valid;
    logic                m_err;
    logic [NI-1:0]       m_reg;

    function automatic int get_sel(input logic [CFG_BITS-1:0] a, input int k, input int m);
        return int'(a[((k*TOTAL_MUX)+m)*SEL_BITS +: SEL_BITS]);
    endfunction

    function automatic logic [CFG_BITS-1:0] put_sel(input logic [CFG_BITS-1:0] c,
                                                    input int k, input int m, input int s);
        c[((k*TOTAL_MUX)+m)*SEL_BITS +: SEL_BITS] = SEL_BITS'(s);
        return c;
    endfunction

    function automatic logic mux_val(input int s, input logic [NT-1:0] sb, input int k);
        if (s < WIDTH) return sb[s*NUM_LE+k];
        if (s == WIDTH + 1) return 1'b1;
        return 1'b0;
    endfunction

    function automatic exp_t predict(input logic [NT-1:0] sb, input logic [NO-1:0] lo);
        exp_t e;
        int   s;
        int   idx;
        e.le_in = '0;
        e.oe    = '0;
        e.out   = '0;
        e.valid = m_valid;
        e.err   = m_err;
        e.cout  = m_shadow[CFG_BITS-1];
        if (m_valid) begin
            for (int k = 0; k < NUM_LE; k++) begin
                for (int i = 0; i < LE_INPUTS; i++) begin
                    idx = k * LE_INPUTS + i;
                    if (m_active[REG_BASE+idx]) e.le_in[idx] = m_reg[idx];
                    else e.le_in[idx] = mux_val(get_sel(m_active, k, i), sb, k);
                end
                for (int o = 0; o < LE_OUTPUTS; o++) begin
                    s = get_sel(m_active, k, LE_INPUTS + o);
                    if (s < WIDTH && !e.oe[s*NUM_LE+k]) begin
                        e.oe[s*NUM_LE+k]  = 1'b1;
                        e.out[s*NUM_LE+k] = lo[k*LE_OUTPUTS+o];
                    end
                end
            end
        end
        return e;
    endfunction

    task automatic model_reset();
        m_shadow = '0;
        m_active = '0;
        m_cnt    = 0;
        m_valid  = 1'b0;
        m_err    = 1'b0;
        m_reg    = '0;
    endtask

    // One clock cycle: drive inputs, queue the expected outputs for this
    // cycle, then advance the model across the clock edge.
    task automatic step(input logic en, input logic din, input logic commit);
        logic [NT-1:0] sb;
        logic [NO-1:0] lo;
        sb         = NT'($urandom());
        lo         = NO'($urandom());
        cfg_en     = en;
        cfg_in     = din;
        cfg_commit = commit;
        sb_in      = sb;
        le_out     = lo;
        exp_q.push_back(predict(sb, lo));
        @(posedge clk);
        if (nrst) begin
            for (int k = 0; k < NUM_LE; k++) begin
                for (int i = 0; i < LE_INPUTS; i++) begin
                    m_reg[k*LE_INPUTS+i] = m_valid &
                                           mux_val(get_sel(m_active, k, i), sb, k);
                end
            end
            if (en) begin
                m_shadow = {m_shadow[CFG_BITS-2:0], din};
                if (m_cnt < CFG_BITS + 1) m_cnt++;
            end else if (commit) begin
                if (m_cnt == CFG_BITS) begin
                    m_active = m_shadow;
                    m_valid  = 1'b1;
                    m_err    = 1'b0;
                end else begin
                    m_err = 1'b1;
                end
                m_cnt = 0;
            end
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int j = 0; j < n; j++) step(1'b0, 1'($urandom()), 1'b0);
    endtask

    // Shift the low nbits of cfg, most significant first, so bit 0 goes last.
    task automatic load(input logic [CFG_BITS-1:0] cfg, input int nbits);
        for (int j = nbits - 1; j >= 0; j--) step(1'b1, cfg[j], 1'b0);
    endtask

    task automatic commit();
        step(1'b0, 1'($urandom()), 1'b1);
    endtask

    task automatic pulse_reset();
        nrst = 1'b0;
        model_reset();
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        nrst = 1'b1;
    endtask

    function automatic logic [CFG_BITS-1:0] rand_cfg();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return CFG_BITS'(r);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
        end
    endtask

    // Monitor: compare every queued expectation against the settled outputs.
    always @(negedge clk) begin
        exp_t e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("le_in",     32'(le_in),     32'(e.le_in));
            chk("sb_oe",     32'(sb_oe),     32'(e.oe));
            chk("sb_out",    32'(sb_out),    32'(e.out));
            chk("cfg_valid", 32'(cfg_valid), 32'(e.valid));
            chk("cfg_err",   32'(cfg_err),   32'(e.err));
            chk("cfg_out",   32'(cfg_out),   32'(e.cout));
        end
    end

    initial begin
        logic [CFG_BITS-1:0] cfg_a, cfg_b, cfg_c;
        nrst       = 1'b0;
        cfg_en     = 1'b0;
        cfg_in     = 1'b0;
        cfg_commit = 1'b0;
        sb_in      = '0;
        le_out     = '0;
        model_reset();
        @(posedge clk);
        #1;
        pulse_reset();
        idle(4);

        // LE0 in0 <- track 3, LE1 in2 <- const 1, LE0 out -> track 5, rest const 0.
        cfg_a = '0;
        for (int k = 0; k < NUM_LE; k++)
            for (int m = 0; m < TOTAL_MUX; m++) cfg_a = put_sel(cfg_a, k, m, WIDTH);
        cfg_a = put_sel(cfg_a, 0, 0, 3);
        cfg_a = put_sel(cfg_a, 1, 2, WIDTH + 1);
        cfg_a = put_sel(cfg_a, 0, LE_INPUTS, 5);
        load(cfg_a, CFG_BITS);
        commit();
        idle(12);

        // Same routing with LE0 in0 registered.
        cfg_b = cfg_a;
        cfg_b[REG_BASE] = 1'b1;
        load(cfg_b, CFG_BITS);
        idle(3);
        commit();
        idle(12);

        // Short load fails, routing stays; a full load then succeeds.
        load(rand_cfg(), CFG_BITS - 1);
        commit();
        idle(5);
        load(rand_cfg(), CFG_BITS);
        commit();
        idle(8);

        // Over-long load saturates the counter and fails.
        load(rand_cfg(), CFG_BITS);
        load(rand_cfg(), 12);
        commit();
        idle(3);

        // Shift wins over a simultaneous commit; the 48th bit is shifted and
        // the following commit succeeds.
        cfg_c = rand_cfg();
        load(cfg_c >> 1, CFG_BITS - 1);
        step(1'b1, cfg_c[0], 1'b1);
        idle(2);
        commit();
        idle(8);

        // Reset mid-shift clears everything; reload restores routing.
        load(rand_cfg(), 20);
        pulse_reset();
        idle(2);
        commit();
        idle(2);
        load(cfg_b, CFG_BITS);
        commit();
        idle(8);

        // Random configurations with random traffic.
        for (int r = 0; r < 25; r++) begin
            load(rand_cfg(), CFG_BITS);
            if (($urandom() % 4) == 0) load(rand_cfg(), 1);
            commit();
            idle(int'($urandom_range(2, 6)));
        end

        repeat (2) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
